spi_byte_receiver: RTL

Downstream consumer of the serial byte-stream transmitter. Takes the single-wire serial line, recovers 8-bit bytes from start/stop-framed LSB-first frames, and presents each byte with a one-cycle valid strobe. Checks that consecutive bytes form the incrementing sequence the transmitter produces, and counts sequence and framing errors for on-board display.

---
 rtl/spi_pkg.sv | 20 ++
 rtl/spi_byte_receiver_if.sv | 28 ++
 rtl/seq_checker.sv | 44 ++++
 rtl/spi_byte_receiver.sv | 138 +++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared state encoding and serial line constants
package spi_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_WAIT  = 3'd4
    } state_t;

    localparam logic LINE_IDLE      = 1'b1;
    localparam int   DATA_BITS      = 8;
    localparam int   DEF_BIT_CYCLES = 100000000;

    function automatic logic [DATA_BITS-1:0] next_seq(input logic [DATA_BITS-1:0] b);
        return b + DATA_BITS'(1);
    endfunction

endpackage

// File: rtl/spi_byte_receiver_if.sv
// rtl/spi_byte_receiver_if.sv - serial input and byte/error outputs of the receiver
interface spi_byte_receiver_if #(
    parameter int CNT_W = 8
) ();
    import spi_pkg::*;

    logic                 mosi;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 frame_err;
    logic                 seq_err;
    logic [CNT_W-1:0]     frame_err_cnt;
    logic [CNT_W-1:0]     seq_err_cnt;
    logic                 busy;

    modport slave (
        input  mosi,
        output rx_data, rx_valid, frame_err, seq_err,
        output frame_err_cnt, seq_err_cnt, busy
    );

    modport master (
        output mosi,
        input  rx_data, rx_valid, frame_err, seq_err,
        input  frame_err_cnt, seq_err_cnt, busy
    );

endinterface

// File: rtl/seq_checker.sv
// rtl/seq_checker.sv - flags bytes that do not follow the previous byte + 1
module seq_checker
    import spi_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [DATA_BITS-1:0] i_byte,
    input  logic                 i_valid,
    output logic                 o_seq_err,
    output logic [CNT_W-1:0]     o_seq_err_cnt
);

    logic [DATA_BITS-1:0] r_prev;
    logic                 r_have_prev;
    logic                 r_seq_err;
    logic [CNT_W-1:0]     r_cnt;
    logic                 w_mismatch;

    // The first byte after reset only seeds the expected sequence.
    assign w_mismatch = i_valid && r_have_prev && (i_byte != next_seq(r_prev));

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_prev      <= '0;
            r_have_prev <= 1'b0;
            r_seq_err   <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_seq_err <= w_mismatch;
            if (w_mismatch && (r_cnt != '1))
                r_cnt <= r_cnt + CNT_W'(1);
            if (i_valid) begin
                r_prev      <= i_byte;
                r_have_prev <= 1'b1;
            end
        end
    end

    assign o_seq_err     = r_seq_err;
    assign o_seq_err_cnt = r_cnt;

endmodule

// File: rtl/spi_byte_receiver.sv
// rtl/spi_byte_receiver.sv - start/stop framed LSB-first byte receiver with error counters
module spi_byte_receiver
    import spi_pkg::*;
#(
    parameter int BIT_CYCLES = DEF_BIT_CYCLES,
    parameter int CNT_W      = 8
) (
    input  logic                i_sclk,
    input  logic                i_reset,
    spi_byte_receiver_if.slave  bus
);

    localparam int            TW        = $clog2(BIT_CYCLES);
    localparam logic [TW-1:0] SAMPLE_PT = TW'(BIT_CYCLES / 2 - 1);
    localparam logic [TW-1:0] LAST_PT   = TW'(BIT_CYCLES - 1);

    state_t               r_state, w_next;
    logic                 r_sync1, r_sync2;
    logic [TW-1:0]        r_cnt;
    logic [2:0]           r_bit_idx;
    logic [DATA_BITS-1:0] r_sh;
    logic [DATA_BITS-1:0] r_rx_data;
    logic                 r_rx_valid;
    logic                 r_frame_err;
    logic [CNT_W-1:0]     r_frame_cnt;

    logic w_ms, w_sample, w_bit_end;
    logic w_shift, w_bit_inc, w_byte_ok, w_frame_bad;
    logic w_seq_err;
    logic [CNT_W-1:0] w_seq_cnt;

    assign w_ms      = r_sync2;
    assign w_sample  = (r_cnt == SAMPLE_PT);
    assign w_bit_end = (r_cnt == LAST_PT);

    always_ff @(posedge i_sclk) begin
        if (i_reset)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        w_shift     = 1'b0;
        w_bit_inc   = 1'b0;
        w_byte_ok   = 1'b0;
        w_frame_bad = 1'b0;
        case (r_state)
            S_IDLE:  if (!w_ms) w_next = S_START;
            S_START: begin
                if (w_sample && w_ms)
                    w_next = S_IDLE;
                else if (w_bit_end)
                    w_next = S_DATA;
            end
            S_DATA: begin
                w_shift = w_sample;
                if (w_bit_end) begin
                    if (r_bit_idx == 3'(DATA_BITS - 1))
                        w_next = S_STOP;
                    else
                        w_bit_inc = 1'b1;
                end
            end
            // Leaving at mid-stop lets the next start bit follow immediately.
            S_STOP: begin
                if (w_sample) begin
                    if (w_ms) begin
                        w_byte_ok = 1'b1;
                        w_next    = S_IDLE;
                    end else begin
                        w_frame_bad = 1'b1;
                        w_next      = S_WAIT;
                    end
                end
            end
            S_WAIT:  if (w_ms) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_sclk) begin
        if (i_reset) begin
            r_sync1     <= LINE_IDLE;
            r_sync2     <= LINE_IDLE;
            r_cnt       <= '0;
            r_bit_idx   <= '0;
            r_sh        <= '0;
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            r_sync1 <= bus.mosi;
            r_sync2 <= r_sync1;

            if ((w_next != r_state) || w_bit_inc)
                r_cnt <= '0;
            else if (r_state inside {S_START, S_DATA, S_STOP})
                r_cnt <= r_cnt + TW'(1);

            if (r_state != S_DATA)
                r_bit_idx <= '0;
            else if (w_bit_inc)
                r_bit_idx <= r_bit_idx + 3'd1;

            if (w_shift)
                r_sh <= {w_ms, r_sh[DATA_BITS-1:1]};

            r_rx_valid <= w_byte_ok;
            if (w_byte_ok)
                r_rx_data <= r_sh;

            r_frame_err <= w_frame_bad;
            if (w_frame_bad && (r_frame_cnt != '1))
                r_frame_cnt <= r_frame_cnt + CNT_W'(1);
        end
    end

    seq_checker #(.CNT_W(CNT_W)) u_seq_checker (
        .i_clk         (i_sclk),
        .i_reset       (i_reset),
        .i_byte        (r_sh),
        .i_valid       (w_byte_ok),
        .o_seq_err     (w_seq_err),
        .o_seq_err_cnt (w_seq_cnt)
    );

    assign bus.rx_data       = r_rx_data;
    assign bus.rx_valid      = r_rx_valid;
    assign bus.frame_err     = r_frame_err;
    assign bus.seq_err       = w_seq_err;
    assign bus.frame_err_cnt = r_frame_cnt;
    assign bus.seq_err_cnt   = w_seq_cnt;
    assign bus.busy          = (r_state != S_IDLE);

endmodule
